// File: rtl/word_packer.sv
// word_packer: gathers RATIO items of IN_WIDTH bits into one output word,
// with a flush request that emits a partial word padded with zero lanes.
// Ports:
//   clk, reset                    - clock, async active-high reset
//   in_val/in_data/in_rdy         - item stream in (FIFO dequeue side)
//   flush/flush_ack               - level flush request, one-cycle ack pulse
//   out_val/out_data/out_keep/out_rdy - packed word out, per-lane keep mask
//   fill_level                    - items currently held in the accumulator
module word_packer #(
  parameter int IN_WIDTH = 8,
  parameter int LOGRATIO = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_val,
  input  logic [IN_WIDTH-1:0]              in_data,
  output logic                             in_rdy,
  input  logic                             flush,
  output logic                             flush_ack,
  output logic                             out_val,
  output logic [(IN_WIDTH<<LOGRATIO)-1:0]  out_data,
  output logic [(1<<LOGRATIO)-1:0]         out_keep,
  input  logic                             out_rdy,
  output logic [LOGRATIO-1:0]              fill_level
);

  localparam int RATIO = 1 << LOGRATIO;
  localparam int OW    = IN_WIDTH * RATIO;
  localparam logic [LOGRATIO-1:0] CNT_MAX = LOGRATIO'(RATIO - 1);

  // Only RATIO-1 lanes are stored: the last item of a word goes straight
  // from in_data into the output register.
  logic [IN_WIDTH-1:0] lanes [RATIO-1];
  logic [LOGRATIO-1:0] cnt;

  logic          slot_free;
  logic          at_max;
  logic          in_fire;
  logic          out_fire;
  logic          complete;
  logic          flush_req;
  logic          flush_exec;
  logic          flush_noop;
  logic          load_word;
  logic [OW-1:0]    word;
  logic [RATIO-1:0] keep;

  assign slot_free = !out_val || out_rdy;
  assign at_max    = (cnt == CNT_MAX);
  assign in_rdy    = !at_max || slot_free;
  assign in_fire   = in_val && in_rdy;
  assign out_fire  = out_val && out_rdy;
  assign complete  = in_fire && at_max;

  // The requester sees the ack at the same time flush is still high; that
  // cycle is the handshake itself, so it is not taken as a fresh request.
  assign flush_req  = flush && !flush_ack;
  assign flush_exec = flush_req && slot_free && ((cnt != '0) || in_fire);
  assign flush_noop = flush_req && (cnt == '0) && !in_fire;
  assign load_word  = complete || flush_exec;

  assign fill_level = cnt;

  // Candidate output word: held lanes below cnt, plus the incoming item in
  // lane cnt when one is accepted this cycle. Lanes at or above cnt may hold
  // stale items from an earlier word, so they are masked to zero here.
  always_comb begin
    word = '0;
    keep = '0;
    for (int i = 0; i < RATIO - 1; i++) begin
      if (LOGRATIO'(i) < cnt) begin
        word[i*IN_WIDTH +: IN_WIDTH] = lanes[i];
        keep[i] = 1'b1;
      end
    end
    if (in_fire) begin
      word[int'(cnt)*IN_WIDTH +: IN_WIDTH] = in_data;
      keep[cnt] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RATIO - 1; i++) begin
        lanes[i] <= '0;
      end
      cnt <= '0;
    end else begin
      if (load_word) begin
        cnt <= '0;
      end else if (in_fire) begin
        // in_fire without load_word implies cnt < RATIO-1, so the lane exists.
        lanes[cnt] <= in_data;
        cnt        <= cnt + LOGRATIO'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_val   <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      flush_ack <= 1'b0;
    end else begin
      flush_ack <= flush_exec || flush_noop;
      if (load_word) begin
        out_val  <= 1'b1;
        out_data <= word;
        out_keep <= keep;
      end else if (out_fire) begin
        out_val <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_word_packer.sv
module tb_word_packer;

  logic        clk;
  logic        reset;
  logic        in_val;
  logic [7:0]  in_data;
  logic        in_rdy;
  logic        flush;
  logic        flush_ack;
  logic        out_val;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_rdy;
  logic [1:0]  fill_level;

  int total;
  int bad;

  word_packer #(.IN_WIDTH(8), .LOGRATIO(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_val     (in_val),
    .in_data    (in_data),
    .in_rdy     (in_rdy),
    .flush      (flush),
    .flush_ack  (flush_ack),
    .out_val    (out_val),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_rdy    (out_rdy),
    .fill_level (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] d);
    in_val  = 1'b1;
    in_data = d;
    tick();
    in_val  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL rst_out_val got=%b exp=0", out_val); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=00000000", out_data); end
    total++; if (out_keep !== 4'h0) begin bad++; $display("FAIL rst_out_keep got=%h exp=0", out_keep); end
    total++; if (fill_level !== 2'd0) begin bad++; $display("FAIL rst_fill got=%0d exp=0", fill_level); end
    total++; if (flush_ack !== 1'b0) begin bad++; $display("FAIL rst_flush_ack got=%b exp=0", flush_ack); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL rst_in_rdy got=%b exp=1", in_rdy); end
    tick();
  endtask

  task automatic test_stream();
    out_rdy = 1'b1;
    feed(8'h11); feed(8'h22); feed(8'h33);
    total++; if (fill_level !== 2'd3) begin bad++; $display("FAIL stream_fill3 got=%0d exp=3", fill_level); end
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL stream_early_val got=%b exp=0", out_val); end
    feed(8'h44);
    total++; if (out_val !== 1'b1) begin bad++; $display("FAIL stream_w1_val got=%b exp=1", out_val); end
    total++; if (out_data !== 32'h44332211) begin bad++; $display("FAIL stream_w1_data got=%h exp=44332211", out_data); end
    total++; if (out_keep !== 4'hF) begin bad++; $display("FAIL stream_w1_keep got=%h exp=f", out_keep); end
    total++; if (fill_level !== 2'd0) begin bad++; $display("FAIL stream_w1_fill got=%0d exp=0", fill_level); end
    feed(8'h55);
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL stream_drain_val got=%b exp=0", out_val); end
    feed(8'h66); feed(8'h77); feed(8'h88);
    total++; if (out_data !== 32'h88776655 || out_val !== 1'b1) begin bad++; $display("FAIL stream_w2 got=%h/%b exp=88776655/1", out_data, out_val); end
    tick();
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL stream_end_val got=%b exp=0", out_val); end
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b0;
    feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44);
    total++; if (out_val !== 1'b1 || out_data !== 32'h44332211) begin bad++; $display("FAIL bp_w1 got=%h/%b exp=44332211/1", out_data, out_val); end
    feed(8'h55); feed(8'h66); feed(8'h77);
    in_val  = 1'b1;
    in_data = 8'h88;
    #1;
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL bp_in_rdy_full got=%b exp=0", in_rdy); end
    tick(); tick();
    total++; if (out_data !== 32'h44332211) begin bad++; $display("FAIL bp_hold_data got=%h exp=44332211", out_data); end
    total++; if (fill_level !== 2'd3 || in_rdy !== 1'b0) begin bad++; $display("FAIL bp_hold_fill got=%0d/%b exp=3/0", fill_level, in_rdy); end
    out_rdy = 1'b1;
    #1;
    total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL bp_in_rdy_release got=%b exp=1", in_rdy); end
    tick();
    in_val = 1'b0;
    total++; if (out_val !== 1'b1 || out_data !== 32'h88776655) begin bad++; $display("FAIL bp_w2 got=%h/%b exp=88776655/1", out_data, out_val); end
    total++; if (fill_level !== 2'd0) begin bad++; $display("FAIL bp_w2_fill got=%0d exp=0", fill_level); end
    tick();
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL bp_end_val got=%b exp=0", out_val); end
  endtask

  task automatic test_flush_partial();
    out_rdy = 1'b1;
    feed(8'hAA); feed(8'hBB);
    flush = 1'b1;
    tick();
    total++; if (out_val !== 1'b1 || out_data !== 32'h0000BBAA) begin bad++; $display("FAIL fp_data got=%h/%b exp=0000bbaa/1", out_data, out_val); end
    total++; if (out_keep !== 4'h3) begin bad++; $display("FAIL fp_keep got=%h exp=3", out_keep); end
    total++; if (flush_ack !== 1'b1) begin bad++; $display("FAIL fp_ack got=%b exp=1", flush_ack); end
    flush = 1'b0;
    tick();
    total++; if (flush_ack !== 1'b0 || out_val !== 1'b0) begin bad++; $display("FAIL fp_after got=%b/%b exp=0/0", flush_ack, out_val); end
  endtask

  task automatic test_flush_with_item();
    out_rdy = 1'b1;
    feed(8'h01); feed(8'h02);
    in_val  = 1'b1;
    in_data = 8'h03;
    flush   = 1'b1;
    tick();
    in_val = 1'b0;
    total++; if (out_data !== 32'h00030201) begin bad++; $display("FAIL fi_data got=%h exp=00030201", out_data); end
    total++; if (out_keep !== 4'h7 || flush_ack !== 1'b1) begin bad++; $display("FAIL fi_keep_ack got=%h/%b exp=7/1", out_keep, flush_ack); end
    total++; if (fill_level !== 2'd0) begin bad++; $display("FAIL fi_fill got=%0d exp=0", fill_level); end
    flush = 1'b0;
    tick();
  endtask

  task automatic test_flush_empty();
    out_rdy = 1'b1;
    flush = 1'b1;
    #1;
    total++; if (flush_ack !== 1'b0) begin bad++; $display("FAIL fe_ack_early got=%b exp=0", flush_ack); end
    tick();
    total++; if (flush_ack !== 1'b1 || out_val !== 1'b0) begin bad++; $display("FAIL fe_ack got=%b/%b exp=1/0", flush_ack, out_val); end
    flush = 1'b0;
    tick();
    total++; if (flush_ack !== 1'b0 || out_val !== 1'b0) begin bad++; $display("FAIL fe_after got=%b/%b exp=0/0", flush_ack, out_val); end
    feed(8'h01); feed(8'h02); feed(8'h03);
    in_val  = 1'b1;
    in_data = 8'h04;
    flush   = 1'b1;
    tick();
    in_val = 1'b0;
    total++; if (out_data !== 32'h04030201 || out_keep !== 4'hF) begin bad++; $display("FAIL f4_word got=%h/%h exp=04030201/f", out_data, out_keep); end
    total++; if (flush_ack !== 1'b1) begin bad++; $display("FAIL f4_ack got=%b exp=1", flush_ack); end
    flush = 1'b0;
    tick();
  endtask

  task automatic test_flush_wait();
    out_rdy = 1'b0;
    feed(8'hC1); feed(8'hC2); feed(8'hC3); feed(8'hC4);
    feed(8'hA1); feed(8'hA2);
    flush = 1'b1;
    tick(); tick();
    total++; if (flush_ack !== 1'b0 || out_data !== 32'hC4C3C2C1) begin bad++; $display("FAIL fw_wait got=%b/%h exp=0/c4c3c2c1", flush_ack, out_data); end
    total++; if (fill_level !== 2'd2) begin bad++; $display("FAIL fw_fill got=%0d exp=2", fill_level); end
    out_rdy = 1'b1;
    tick();
    total++; if (out_val !== 1'b1 || out_data !== 32'h0000A2A1 || out_keep !== 4'h3) begin bad++; $display("FAIL fw_word got=%b/%h/%h exp=1/0000a2a1/3", out_val, out_data, out_keep); end
    total++; if (flush_ack !== 1'b1) begin bad++; $display("FAIL fw_ack got=%b exp=1", flush_ack); end
    flush = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    out_rdy = 1'b1;
    feed(8'hE1); feed(8'hE2);
    reset = 1'b1;
    #1;
    total++; if (fill_level !== 2'd0 || out_val !== 1'b0) begin bad++; $display("FAIL rm1 got=%0d/%b exp=0/0", fill_level, out_val); end
    reset = 1'b0;
    tick();
    out_rdy = 1'b0;
    feed(8'hF1); feed(8'hF2); feed(8'hF3); feed(8'hF4);
    feed(8'hF5); feed(8'hF6);
    flush = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    total++; if (out_val !== 1'b0 || out_data !== 32'h0 || out_keep !== 4'h0) begin bad++; $display("FAIL rm2 got=%b/%h/%h exp=0/00000000/0", out_val, out_data, out_keep); end
    total++; if (fill_level !== 2'd0 || flush_ack !== 1'b0) begin bad++; $display("FAIL rm2_fill got=%0d/%b exp=0/0", fill_level, flush_ack); end
    flush = 1'b0;
    #2;
    reset = 1'b0;
    tick();
    total++; if (flush_ack !== 1'b0 || out_val !== 1'b0) begin bad++; $display("FAIL rm_noack got=%b/%b exp=0/0", flush_ack, out_val); end
    out_rdy = 1'b1;
    feed(8'h5A); feed(8'h6B); feed(8'h7C); feed(8'h8D);
    total++; if (out_val !== 1'b1 || out_data !== 32'h8D7C6B5A || out_keep !== 4'hF) begin bad++; $display("FAIL rm_clean got=%b/%h/%h exp=1/8d7c6b5a/f", out_val, out_data, out_keep); end
    tick();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    in_val  = 1'b0;
    in_data = 8'h00;
    flush   = 1'b0;
    out_rdy = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_partial();
    test_flush_with_item();
    test_flush_empty();
    test_flush_wait();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_packer.md
WORD_PACKER -- requirements
Module: word_packer

Interface
REQ-001 Parameter IN_WIDTH, default 8: bit width of one input item.
REQ-002 Parameter LOGRATIO, default 2: log2 of items per output word; RATIO = 1 << LOGRATIO.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_val  input  1  upstream item valid; connects to a FIFO deq_val.
REQ-006 in_data  input  IN_WIDTH  upstream item; connects to a FIFO deq_data.
REQ-007 in_rdy  output  1  packer accepts item; connects to a FIFO deq_rdy.
REQ-008 flush  input  1  level request to emit the partial word; held until flush_ack.
REQ-009 flush_ack  output  1  one-cycle pulse: flush request completed.
REQ-010 out_val  output  1  output word valid.
REQ-011 out_data  output  IN_WIDTH*RATIO  packed word; the first-accepted item occupies bits [IN_WIDTH-1:0].
REQ-012 out_keep  output  RATIO  per-lane valid mask for out_data.
REQ-013 out_rdy  input  1  downstream accepts word.
REQ-014 fill_level  output  LOGRATIO  number of items held in the accumulator (0..RATIO-1).

Function
REQ-015 in_fire = in_val & in_rdy; out_fire = out_val & out_rdy; slot_free = !out_val | out_rdy.
REQ-016 Accumulator: RATIO-1 lanes of IN_WIDTH bits plus counter cnt (= fill_level); on in_fire with cnt < RATIO-1, in_data is written to lane cnt and cnt increments.
REQ-017 in_rdy = 1 when cnt < RATIO-1; in_rdy = slot_free when cnt == RATIO-1.
REQ-018 Word completion: in_fire with cnt == RATIO-1 loads out_data = {in_data, lanes RATIO-2..0}, out_keep = all ones, out_val = 1, and cnt = 0, all on the same edge.
REQ-019 Flush executes in a cycle with flush = 1, slot_free = 1, and either cnt > 0 or in_fire.
REQ-020 A flush whose same-cycle in_fire does not complete a word includes that item: out_keep has the low (cnt+1) bits set, and unused lanes of out_data are 0.
REQ-021 A flush without a same-cycle in_fire emits the cnt held lanes with out_keep low cnt bits set; cnt becomes 0 and out_val becomes 1.
REQ-022 flush coinciding with a word-completing in_fire: the full word of REQ-018 is emitted; flush counts as executed.
REQ-023 flush with cnt == 0 and no in_fire: no word is emitted; flush_ack pulses on the next edge.
REQ-024 flush_ack is registered and is 1 for exactly the cycle after the flush executes (or is a no-op); a flush still held high after its ack is a new request.
REQ-025 A flush with slot_free = 0 and data held waits; accumulator content and in_rdy still follow REQ-016/017.
REQ-026 out_val clears on out_fire unless a new word loads on the same edge; out_data and out_keep are stable while out_val & !out_rdy.
REQ-027 Latency: a word is visible on out_val one cycle after its last item's in_fire; throughput is one word per RATIO cycles with no stalls.
REQ-028 Counter arithmetic wraps only via the explicit return to 0; cnt never exceeds RATIO-1.

Reset
REQ-029 While reset = 1, asynchronously: cnt = 0, out_val = 0, out_data = 0, out_keep = 0, flush_ack = 0; lane storage is cleared.
REQ-030 Reset asserted mid-word discards the partial word and any pending output word; no flush_ack is emitted for a pending flush.
REQ-031 After reset deassertion, in_rdy = 1 in the first cycle.

Verification (IN_WIDTH=8, LOGRATIO=2)
REQ-032 Stream 11,22,33,44 with out_rdy=1 -> next cycle out_val=1, out_data=0x44332211, out_keep=0xF, fill_level=0.
REQ-033 out_rdy=0, stream 8 items -> first word held stable; in_rdy=0 at cnt=3 until out_rdy=1; second word is 0x88776655 with no item lost.
REQ-034 Items AA,BB then flush=1 (no in_val) -> out_data=0x0000BBAA, out_keep=0x3, then flush_ack for one cycle.
REQ-035 Items 01,02 then flush together with item 03 -> out_data=0x00030201, out_keep=0x7.
REQ-036 flush with fill_level=0 -> no out_val, flush_ack one cycle later; flush with a 4th item -> full word, keep=0xF.
REQ-037 reset pulsed after 2 items and again with out_val=1 -> all outputs 0 immediately; next 4 items form a clean word.
